// File: rtl/text_term_pkg.sv
// Shared types and constants for the character-terminal front end:
// FSM state encoding, PS/2 set-2 scan codes and default buffer geometry.
package text_term_pkg;

  localparam int COLS_DEFAULT = 70;
  localparam int ROWS_DEFAULT = 30;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_POP,
    ST_DECODE,
    ST_WRITE,
    ST_CLEAR
  } tt_state_t;

  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_ENTER  = 8'h5A;
  localparam logic [7:0] SC_BKSP   = 8'h66;
  localparam logic [7:0] SC_SPACE  = 8'h29;

endpackage

// File: rtl/text_term_scancode_ascii.sv
// Combinational set-2 make-code to ASCII translation for letters, digits and space.
// Digits are only printable unshifted; shifted letters come out upper case.
module scancode_ascii
  import text_term_pkg::*;
(
  input  logic [7:0] code,
  input  logic       shift,
  output logic [7:0] ascii,
  output logic       printable
);

  logic [7:0] letter;
  logic [7:0] digit;

  always_comb begin
    letter = 8'h00;
    unique case (code)
      8'h1C: letter = "a";  8'h32: letter = "b";  8'h21: letter = "c";
      8'h23: letter = "d";  8'h24: letter = "e";  8'h2B: letter = "f";
      8'h34: letter = "g";  8'h33: letter = "h";  8'h43: letter = "i";
      8'h3B: letter = "j";  8'h42: letter = "k";  8'h4B: letter = "l";
      8'h3A: letter = "m";  8'h31: letter = "n";  8'h44: letter = "o";
      8'h4D: letter = "p";  8'h15: letter = "q";  8'h2D: letter = "r";
      8'h1B: letter = "s";  8'h2C: letter = "t";  8'h3C: letter = "u";
      8'h2A: letter = "v";  8'h1D: letter = "w";  8'h22: letter = "x";
      8'h35: letter = "y";  8'h1A: letter = "z";
      default: letter = 8'h00;
    endcase
  end

  always_comb begin
    digit = 8'h00;
    unique case (code)
      8'h45: digit = "0";  8'h16: digit = "1";  8'h1E: digit = "2";
      8'h26: digit = "3";  8'h25: digit = "4";  8'h2E: digit = "5";
      8'h36: digit = "6";  8'h3D: digit = "7";  8'h3E: digit = "8";
      8'h46: digit = "9";
      default: digit = 8'h00;
    endcase
  end

  always_comb begin
    ascii     = 8'h00;
    printable = 1'b0;
    if (letter != 8'h00) begin
      ascii     = shift ? (letter - 8'h20) : letter;
      printable = 1'b1;
    end else if (digit != 8'h00 && !shift) begin
      ascii     = digit;
      printable = 1'b1;
    end else if (code == SC_SPACE) begin
      ascii     = 8'h20;
      printable = 1'b1;
    end
  end

endmodule

// File: rtl/text_term.sv
// Keyboard-to-character-buffer terminal: pops PS/2 bytes, tracks shift/break/extended
// prefixes and writes ASCII at a wrapping hardware cursor, clearing each new row.
module text_term
  import text_term_pkg::*;
#(
  parameter int         COLS  = COLS_DEFAULT,
  parameter int         ROWS  = ROWS_DEFAULT,
  parameter logic [7:0] BLANK = 8'h00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  kb_data,
  input  logic        kb_ready,
  input  logic        kb_overflow,
  output logic        kb_nextdata_n,
  output logic        wr_en,
  output logic [11:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic [6:0]  cursor_col,
  output logic [4:0]  cursor_row,
  output logic [7:0]  key_count,
  output logic        ovf_seen
);

  localparam logic [6:0] LAST_COL = 7'(COLS - 1);
  localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);

  tt_state_t   state_q, state_d;
  logic [7:0]  byte_q, byte_d;
  logic        brk_q, brk_d, ext_q, ext_d, shift_q, shift_d;
  logic [6:0]  col_q, col_d, clr_col_q, clr_col_d;
  logic [4:0]  row_q, row_d;
  logic [7:0]  key_count_q, key_count_d;
  logic        ovf_q, ovf_d;
  logic [7:0]  wr_char_q, wr_char_d;
  logic        wr_print_q, wr_print_d;
  logic        wr_en_q, wr_en_d, pop_n_q, pop_n_d;
  logic [11:0] wr_addr_q, wr_addr_d;
  logic [7:0]  wr_data_q, wr_data_d;

  logic [7:0] ascii;
  logic       printable;
  logic       is_shift_code;
  logic [4:0] row_next;

  scancode_ascii u_map (
    .code      (byte_q),
    .shift     (shift_q),
    .ascii     (ascii),
    .printable (printable)
  );

  assign is_shift_code = (byte_q == SC_LSHIFT) || (byte_q == SC_RSHIFT);
  assign row_next      = (row_q == LAST_ROW) ? 5'd0 : row_q + 5'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_CLEAR;
      byte_q      <= 8'h00;
      brk_q       <= 1'b0;
      ext_q       <= 1'b0;
      shift_q     <= 1'b0;
      col_q       <= 7'd0;
      row_q       <= 5'd0;
      clr_col_q   <= 7'd0;
      key_count_q <= 8'd0;
      ovf_q       <= 1'b0;
      wr_char_q   <= 8'h00;
      wr_print_q  <= 1'b0;
      wr_en_q     <= 1'b0;
      pop_n_q     <= 1'b1;
      wr_addr_q   <= 12'd0;
      wr_data_q   <= 8'h00;
    end else begin
      state_q     <= state_d;
      byte_q      <= byte_d;
      brk_q       <= brk_d;
      ext_q       <= ext_d;
      shift_q     <= shift_d;
      col_q       <= col_d;
      row_q       <= row_d;
      clr_col_q   <= clr_col_d;
      key_count_q <= key_count_d;
      ovf_q       <= ovf_d;
      wr_char_q   <= wr_char_d;
      wr_print_q  <= wr_print_d;
      wr_en_q     <= wr_en_d;
      pop_n_q     <= pop_n_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (kb_ready) state_d = ST_POP;
      ST_POP:    state_d = ST_DECODE;
      ST_DECODE: begin
        if (byte_q == SC_BREAK || byte_q == SC_EXT || ext_q || brk_q || is_shift_code)
          state_d = ST_IDLE;
        else if (byte_q == SC_ENTER)
          state_d = ST_CLEAR;
        else if (byte_q == SC_BKSP)
          state_d = (col_q != 7'd0) ? ST_WRITE : ST_IDLE;
        else
          state_d = printable ? ST_WRITE : ST_IDLE;
      end
      ST_WRITE:  state_d = (wr_print_q && col_q == LAST_COL) ? ST_CLEAR : ST_IDLE;
      // Right after reset the clear has no write outstanding yet, so it waits one cycle.
      ST_CLEAR:  if (wr_en_q && clr_col_q == LAST_COL) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    byte_d      = byte_q;
    brk_d       = brk_q;
    ext_d       = ext_q;
    shift_d     = shift_q;
    col_d       = col_q;
    row_d       = row_q;
    clr_col_d   = clr_col_q;
    key_count_d = key_count_q;
    wr_char_d   = wr_char_q;
    wr_print_d  = wr_print_q;
    ovf_d       = ovf_q | kb_overflow;
    unique case (state_q)
      ST_IDLE: if (kb_ready) byte_d = kb_data;
      ST_DECODE: begin
        if (byte_q == SC_BREAK) begin
          brk_d = 1'b1;
        end else if (byte_q == SC_EXT) begin
          ext_d = 1'b1;
        end else if (ext_q) begin
          ext_d = 1'b0;
          brk_d = 1'b0;
        end else if (brk_q) begin
          brk_d = 1'b0;
          if (is_shift_code) shift_d = 1'b0;
        end else if (is_shift_code) begin
          shift_d = 1'b1;
        end else if (byte_q == SC_ENTER) begin
          col_d     = 7'd0;
          row_d     = row_next;
          clr_col_d = 7'd0;
        end else if (byte_q == SC_BKSP) begin
          if (col_q != 7'd0) col_d = col_q - 7'd1;
          wr_char_d  = BLANK;
          wr_print_d = 1'b0;
        end else begin
          wr_char_d  = ascii;
          wr_print_d = 1'b1;
        end
      end
      ST_WRITE: begin
        // An erase leaves the cursor on the blanked cell.
        if (wr_print_q) begin
          key_count_d = key_count_q + 8'd1;
          if (col_q == LAST_COL) begin
            col_d     = 7'd0;
            row_d     = row_next;
            clr_col_d = 7'd0;
          end else begin
            col_d = col_q + 7'd1;
          end
        end
      end
      ST_CLEAR: if (wr_en_q && clr_col_q != LAST_COL) clr_col_d = clr_col_q + 7'd1;
      default: ;
    endcase
  end

  always_comb begin
    wr_en_d   = (state_d == ST_WRITE) || (state_d == ST_CLEAR);
    pop_n_d   = (state_d != ST_POP);
    wr_addr_d = {row_d, (state_d == ST_CLEAR) ? clr_col_d : col_d};
    wr_data_d = (state_d == ST_WRITE) ? wr_char_d : BLANK;
  end

  assign kb_nextdata_n = pop_n_q;
  assign wr_en         = wr_en_q;
  assign wr_addr       = wr_addr_q;
  assign wr_data       = wr_data_q;
  assign cursor_col    = col_q;
  assign cursor_row    = row_q;
  assign key_count     = key_count_q;
  assign ovf_seen      = ovf_q;

endmodule

// File: tb/tb_text_term.sv
// Scoreboarded bench for text_term: a keyboard-FIFO model feeds scan codes, a terminal
// model predicts buffer writes and cursor state, and a monitor checks each DUT write.
module tb_text_term;

  localparam int COLS = 70;
  localparam int ROWS = 30;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  kb_data = 8'h00;
  logic        kb_ready = 1'b0;
  logic        kb_overflow = 1'b0;
  logic        kb_nextdata_n;
  logic        wr_en;
  logic [11:0] wr_addr;
  logic [7:0]  wr_data;
  logic [6:0]  cursor_col;
  logic [4:0]  cursor_row;
  logic [7:0]  key_count;
  logic        ovf_seen;

  always #5 clk = ~clk;

  text_term dut (
    .clk(clk), .rst(rst), .kb_data(kb_data), .kb_ready(kb_ready),
    .kb_overflow(kb_overflow), .kb_nextdata_n(kb_nextdata_n), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .cursor_col(cursor_col),
    .cursor_row(cursor_row), .key_count(key_count), .ovf_seen(ovf_seen)
  );

  int checks = 0;
  int passed = 0;
  int pops = 0;
  int sent = 0;
  logic        prev_pop = 1'b0;
  logic [19:0] exp_q[$];
  logic [7:0]  fifo_q[$];

  int m_col, m_row, m_kc;
  bit m_shift, m_brk, m_ext;

  task automatic check(string name, int act, int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0h required %0h", name, act, exp);
  endtask

  // Keyboard FIFO model plus write monitor, both away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (!kb_nextdata_n) begin
        pops++;
        if (prev_pop) check("pop_pulse_width", 2, 1);
        if (fifo_q.size() > 0) void'(fifo_q.pop_front());
      end
      prev_pop = !kb_nextdata_n;
      if (wr_en) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_write: got addr=%h data=%h required no write", wr_addr, wr_data);
        end else begin
          logic [19:0] e;
          e = exp_q.pop_front();
          $display("write addr=%h data=%h expected %h", wr_addr, wr_data, e);
          check("write", int'({wr_addr, wr_data}), int'(e));
        end
      end
    end else begin
      prev_pop = 1'b0;
    end
    kb_ready = (fifo_q.size() != 0);
    kb_data  = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
  end

  function automatic int to_ascii(logic [7:0] code, bit sh);
    string      letters = "abcdefghijklmnopqrstuvwxyz";
    logic [7:0] lc[26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                           8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                           8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    logic [7:0] dc[10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
    for (int i = 0; i < 26; i++)
      if (code == lc[i]) return sh ? int'(letters[i]) - 32 : int'(letters[i]);
    if (!sh)
      for (int i = 0; i < 10; i++)
        if (code == dc[i]) return 48 + i;
    if (code == 8'h29) return 32;
    return -1;
  endfunction

  task automatic exp_write(int row, int col, int d);
    logic [4:0] r;
    logic [6:0] c;
    logic [7:0] v;
    r = row[4:0];
    c = col[6:0];
    v = d[7:0];
    exp_q.push_back({r, c, v});
  endtask

  task automatic clear_row(int row);
    for (int c = 0; c < COLS; c++) exp_write(row, c, 0);
  endtask

  task automatic model_newline();
    m_col = 0;
    m_row = (m_row + 1) % ROWS;
    clear_row(m_row);
  endtask

  task automatic send(logic [7:0] b);
    int ch;
    fifo_q.push_back(b);
    sent++;
    if (b == 8'hF0) m_brk = 1;
    else if (b == 8'hE0) m_ext = 1;
    else if (m_ext) begin m_ext = 0; m_brk = 0; end
    else if (m_brk) begin
      m_brk = 0;
      if (b == 8'h12 || b == 8'h59) m_shift = 0;
    end
    else if (b == 8'h12 || b == 8'h59) m_shift = 1;
    else if (b == 8'h5A) model_newline();
    else if (b == 8'h66) begin
      if (m_col > 0) begin m_col--; exp_write(m_row, m_col, 0); end
    end else begin
      ch = to_ascii(b, m_shift);
      if (ch >= 0) begin
        exp_write(m_row, m_col, ch);
        m_kc = (m_kc + 1) % 256;
        if (m_col == COLS - 1) model_newline();
        else m_col++;
      end
    end
  endtask

  task automatic drain(string name);
    int n = 0;
    while ((fifo_q.size() != 0 || exp_q.size() != 0) && n < 20000) begin
      @(posedge clk);
      n++;
    end
    repeat (8) @(posedge clk);
    #1;
    if (n >= 20000) begin
      checks++;
      $display("FAIL %s_timeout: got pending=%0d required 0", name, exp_q.size());
      exp_q.delete();
    end
    check({name, "_col"}, int'(cursor_col), m_col);
    check({name, "_row"}, int'(cursor_row), m_row);
    check({name, "_key_count"}, int'(key_count), m_kc);
    check({name, "_pops"}, pops, sent);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    exp_q.delete();
    fifo_q.delete();
    repeat (2) @(posedge clk);
    #1;
    check("rst_wr_en", int'(wr_en), 0);
    check("rst_nextdata_n", int'(kb_nextdata_n), 1);
    check("rst_cursor", int'({cursor_row, cursor_col}), 0);
    check("rst_key_count", int'(key_count), 0);
    check("rst_ovf_seen", int'(ovf_seen), 0);
    m_col = 0; m_row = 0; m_kc = 0; m_shift = 0; m_brk = 0; m_ext = 0;
    pops = 0; sent = 0;
    clear_row(0);
    rst = 1'b0;
    drain("reset_clear");
  endtask

  initial begin
    logic [7:0] pool[16] = '{8'h1C, 8'h32, 8'h1A, 8'h45, 8'h16, 8'h29, 8'h12, 8'h59,
                             8'hF0, 8'hE0, 8'h66, 8'h75, 8'h76, 8'h5A, 8'h4D, 8'h46};
    do_reset();

    send(8'h1C); send(8'hF0); send(8'h1C);
    drain("single_a");

    send(8'h12); send(8'h1C); send(8'hF0); send(8'h1C);
    send(8'hF0); send(8'h12); send(8'h1C);
    drain("shift_a");

    send(8'h5A);
    for (int i = 0; i < COLS; i++) send(8'h45);
    drain("wrap_zeros");

    while (m_row != ROWS - 1) send(8'h5A);
    repeat (5) send(8'h29);
    drain("to_last_row");
    send(8'h5A);
    drain("enter_wrap");
    send(8'h66);
    drain("bksp_col0");
    send(8'h1C); send(8'h66);
    drain("bksp_erase");

    send(8'hE0); send(8'h75); send(8'h1C);
    send(8'hE0); send(8'hF0); send(8'h75);
    drain("extended");

    for (int i = 0; i < 300; i++) send(pool[$urandom_range(0, 15)]);
    drain("random");

    @(posedge clk); #1 kb_overflow = 1'b1;
    @(posedge clk); #1 kb_overflow = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("ovf_set", int'(ovf_seen), 1);
    send(8'h24);
    drain("after_ovf");
    check("ovf_sticky", int'(ovf_seen), 1);

    send(8'h5A);
    repeat (20) @(posedge clk);
    #1 do_reset();
    send(8'h24);
    drain("after_mid_clear_reset");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
